p_u_bam_pipe: RTL



---
 rtl/p_u_bam_pipe.sv | 103 ++++++++++
 1 files changed

// File: rtl/p_u_bam_pipe.sv
// Streaming unsigned broken-array multiplier: exact or row/column-truncated N x N product,
// carried through a global-stall valid/ready pipeline of PIPE_STAGES registers.
module p_u_bam_pipe #(
  parameter int N           = 8,
  parameter int H_CUT       = 4,
  parameter int V_CUT       = 10,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_approx,
  output logic             busy,
  output logic [15:0]      beat_cnt
);

  localparam int W = 2 * N;

  logic [PIPE_STAGES-1:0] v_r;
  logic [W-1:0]           p_r [PIPE_STAGES];
  logic                   approx_r [PIPE_STAGES];
  logic [15:0]            beat_cnt_r;
  logic                   advance_s;
  logic [W-1:0]           exact_s;
  logic [W-1:0]           approx_s;
  logic [W-1:0]           prod_s;

  // Constant per-row mask of kept multiplicand bits; zero bits let synthesis drop the pp gates.
  function automatic logic [N-1:0] keep_mask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (j >= H_CUT) && ((i + j) >= V_CUT);
    end
    return m;
  endfunction

  assign advance_s = !v_r[PIPE_STAGES-1] || out_ready;
  assign in_ready  = advance_s;

  assign exact_s = W'(in_a) * W'(in_b);

  // Truncated array: sum of masked rows, carries propagate exactly to the top column.
  always_comb begin
    approx_s = '0;
    for (int j = 0; j < N; j++) begin
      approx_s = approx_s + ((W'(in_a & keep_mask(j)) & {W{in_b[j]}}) << j);
    end
  end

  // Per-beat mode selection ahead of the first pipeline register.
  always_comb begin
    prod_s = '0;
    if (in_approx) begin
      prod_s = approx_s;
    end else begin
      prod_s = exact_s;
    end
  end

  // Pipeline stages: all shift together on advance, all hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        p_r[s]      <= '0;
        approx_r[s] <= 1'b0;
      end
    end else if (advance_s) begin
      v_r[0]      <= in_valid;
      p_r[0]      <= prod_s;
      approx_r[0] <= in_approx;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        v_r[s]      <= v_r[s-1];
        p_r[s]      <= p_r[s-1];
        approx_r[s] <= approx_r[s-1];
      end
    end
  end

  // Completed output handshakes, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= 16'd0;
    end else if (v_r[PIPE_STAGES-1] && out_ready) begin
      beat_cnt_r <= beat_cnt_r + 16'd1;
    end
  end

  assign out_valid  = v_r[PIPE_STAGES-1];
  assign out_p      = p_r[PIPE_STAGES-1];
  assign out_approx = approx_r[PIPE_STAGES-1];
  assign busy       = |v_r;
  assign beat_cnt   = beat_cnt_r;

endmodule
